// File: rtl/scr1_tcm_acc_pkg.sv
// Shared types and constants for the TCM vector-add accelerator.
// Also carries the core memory-interface definitions the accelerator snoops.
package scr1_tcm_acc_pkg;

    localparam int unsigned SCR1_IMEM_AWIDTH = 32;
    localparam int unsigned SCR1_DMEM_AWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_ACC_IDLE,
        SCR1_ACC_RD_A,
        SCR1_ACC_RD_B,
        SCR1_ACC_WR
    } type_scr1_acc_state_e;

    // Word offsets inside the 32-byte control window
    localparam logic [2:0] SCR1_ACC_CSR_SRCA = 3'd0;
    localparam logic [2:0] SCR1_ACC_CSR_SRCB = 3'd1;
    localparam logic [2:0] SCR1_ACC_CSR_DST  = 3'd2;
    localparam logic [2:0] SCR1_ACC_CSR_LEN  = 3'd3;
    localparam logic [2:0] SCR1_ACC_CSR_CTRL = 3'd4;

    localparam int unsigned SCR1_ACC_LEN_W = 16;

endpackage : scr1_tcm_acc_pkg

// File: rtl/scr1_tcm_acc_csr.sv
// Control window decode for the vector-add accelerator: snoops core data writes,
// holds SRC_A/SRC_B/DST/LEN and produces a start pulse while idle.
module scr1_tcm_acc_csr
    import scr1_tcm_acc_pkg::*;
#(
    parameter int unsigned                         AW           = 16,
    parameter logic [SCR1_DMEM_AWIDTH-1:0]         ACC_CSR_BASE = SCR1_DMEM_AWIDTH'('h000F0000)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dmem_req,
    input  type_scr1_mem_cmd_e            dmem_cmd,
    input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
    input  logic [31:0]                   dmem_wdata,
    input  logic                          busy,
    output logic [AW-3:0]                 src_a,
    output logic [AW-3:0]                 src_b,
    output logic [AW-3:0]                 dst,
    output logic [SCR1_ACC_LEN_W-1:0]     len,
    output logic                          start
);

    logic       csr_wr;
    logic [2:0] csr_off;
    logic       unused_bits;

    assign csr_off = dmem_addr[4:2];
    assign csr_wr  = dmem_req && (dmem_cmd == SCR1_MEM_CMD_WR)
                  && (dmem_addr[31:5] == ACC_CSR_BASE[31:5]) && !busy;
    assign start   = csr_wr && (csr_off == SCR1_ACC_CSR_CTRL) && dmem_wdata[0];

    // Sub-word address bits and upper data bits carry no meaning here
    assign unused_bits = ^{dmem_addr[1:0], dmem_wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_a <= '0;
            src_b <= '0;
            dst   <= '0;
            len   <= '0;
        end else if (csr_wr) begin
            case (csr_off)
                SCR1_ACC_CSR_SRCA: src_a <= dmem_wdata[AW-1:2];
                SCR1_ACC_CSR_SRCB: src_b <= dmem_wdata[AW-1:2];
                SCR1_ACC_CSR_DST:  dst   <= dmem_wdata[AW-1:2];
                SCR1_ACC_CSR_LEN:  len   <= dmem_wdata[SCR1_ACC_LEN_W-1:0];
                default: ;
            endcase
        end
    end

endmodule : scr1_tcm_acc_csr

// File: rtl/scr1_tcm_vadd_acc.sv
// TCM port-B vector-add accelerator: C[i] = A[i] + B[i] over LEN words,
// three cycles per element (read A, read B, write C).
module scr1_tcm_vadd_acc
    import scr1_tcm_acc_pkg::*;
#(
    parameter logic [SCR1_IMEM_AWIDTH-1:0] SCR1_TCM_SIZE = SCR1_IMEM_AWIDTH'('h00010000),
    parameter logic [SCR1_DMEM_AWIDTH-1:0] ACC_CSR_BASE  = SCR1_DMEM_AWIDTH'('h000F0000),
    localparam int unsigned                AW            = $clog2(SCR1_TCM_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dmem_req,
    input  type_scr1_mem_cmd_e            dmem_cmd,
    input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
    input  logic [31:0]                   dmem_wdata,
    input  logic [31:0]                   mem_rdata,
    output logic                          enable,
    output logic                          mem_ren,
    output logic                          mem_wen,
    output logic [3:0]                    mem_be,
    output logic [AW-3:0]                 mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic                          acc_busy,
    output logic                          acc_done
);

    localparam logic [AW-3:0]             PTR_ONE = {{(AW-3){1'b0}}, 1'b1};
    localparam logic [SCR1_ACC_LEN_W-1:0] LEN_ONE = {{(SCR1_ACC_LEN_W-1){1'b0}}, 1'b1};

    type_scr1_acc_state_e       state, state_next;
    logic [AW-3:0]              src_a, src_b, dst;
    logic [SCR1_ACC_LEN_W-1:0]  len;
    logic                       start;

    logic [AW-3:0]              pa, pb, pd;
    logic [AW-3:0]              pa_next, pb_next, pd_next, addr_next;
    logic [SCR1_ACC_LEN_W-1:0]  cnt, cnt_next;
    logic                       done_next;
    logic [31:0]                a_reg;

    scr1_tcm_acc_csr #(
        .AW           (AW),
        .ACC_CSR_BASE (ACC_CSR_BASE)
    ) i_csr (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmem_req   (dmem_req),
        .dmem_cmd   (dmem_cmd),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .busy       (acc_busy),
        .src_a      (src_a),
        .src_b      (src_b),
        .dst        (dst),
        .len        (len),
        .start      (start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCR1_ACC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pa_next    = pa;
        pb_next    = pb;
        pd_next    = pd;
        cnt_next   = cnt;
        done_next  = acc_done;
        addr_next  = '0;
        case (state)
            SCR1_ACC_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_next = SCR1_ACC_RD_A;
                        pa_next    = src_a;
                        pb_next    = src_b;
                        pd_next    = dst;
                        cnt_next   = len;
                        done_next  = 1'b0;
                    end else begin
                        done_next  = 1'b1;
                    end
                end
            end
            SCR1_ACC_RD_A: state_next = SCR1_ACC_RD_B;
            SCR1_ACC_RD_B: state_next = SCR1_ACC_WR;
            SCR1_ACC_WR: begin
                pa_next  = pa + PTR_ONE;
                pb_next  = pb + PTR_ONE;
                pd_next  = pd + PTR_ONE;
                cnt_next = cnt - LEN_ONE;
                if (cnt == LEN_ONE) begin
                    state_next = SCR1_ACC_IDLE;
                    done_next  = 1'b1;
                end else begin
                    state_next = SCR1_ACC_RD_A;
                end
            end
            default: state_next = SCR1_ACC_IDLE;
        endcase
        // Address is decoded from the upcoming state so it can be registered
        case (state_next)
            SCR1_ACC_RD_A: addr_next = pa_next;
            SCR1_ACC_RD_B: addr_next = pb_next;
            SCR1_ACC_WR:   addr_next = pd_next;
            default:       addr_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa       <= '0;
            pb       <= '0;
            pd       <= '0;
            cnt      <= '0;
            a_reg    <= '0;
            enable   <= 1'b0;
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_be   <= '0;
            mem_addr <= '0;
            acc_done <= 1'b0;
        end else begin
            pa       <= pa_next;
            pb       <= pb_next;
            pd       <= pd_next;
            cnt      <= cnt_next;
            enable   <= (state_next != SCR1_ACC_IDLE);
            mem_ren  <= (state_next == SCR1_ACC_RD_A) || (state_next == SCR1_ACC_RD_B);
            mem_wen  <= (state_next == SCR1_ACC_WR);
            mem_be   <= (state_next == SCR1_ACC_WR) ? '1 : '0;
            mem_addr <= addr_next;
            acc_done <= done_next;
            if (state == SCR1_ACC_RD_B) begin
                a_reg <= mem_rdata;
            end
        end
    end

    // B arrives during the WR cycle itself, so the sum feeds the TCM write register directly
    assign mem_wdata = mem_wen ? (a_reg + mem_rdata) : '0;
    assign acc_busy  = enable;

endmodule : scr1_tcm_vadd_acc

// File: tb/tb_scr1_tcm_vadd_acc.sv
// Self-checking bench for scr1_tcm_vadd_acc: TCM port-B memory, a per-cycle
// reference model of the accelerator schedule, and directed scenarios.
module tb_scr1_tcm_vadd_acc;
    import scr1_tcm_acc_pkg::*;

    localparam int unsigned WA   = 14;
    localparam logic [31:0] BASE = 32'h000F0000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               dmem_req = 1'b0;
    type_scr1_mem_cmd_e dmem_cmd = SCR1_MEM_CMD_RD;
    logic [31:0]        dmem_addr = '0;
    logic [31:0]        dmem_wdata = '0;
    logic [31:0]        mem_rdata;
    logic               enable, mem_ren, mem_wen, acc_busy, acc_done;
    logic [3:0]         mem_be;
    logic [WA-1:0]      mem_addr;
    logic [31:0]        mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scr1_tcm_vadd_acc #(
        .SCR1_TCM_SIZE (32'h00010000),
        .ACC_CSR_BASE  (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmem_req   (dmem_req),
        .dmem_cmd   (dmem_cmd),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .mem_rdata  (mem_rdata),
        .enable     (enable),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .acc_busy   (acc_busy),
        .acc_done   (acc_done)
    );

    // TCM port B: synchronous read, one-cycle latency, byte-enabled write
    logic [31:0]   tcm [0:(1<<WA)-1];
    logic [31:0]   rdata_q = '0;
    logic          poke_en = 1'b0;
    logic [WA-1:0] poke_addr = '0;
    logic [31:0]   poke_data = '0;

    assign mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (poke_en) tcm[poke_addr] <= poke_data;
        if (enable && mem_wen)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) tcm[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (enable && mem_ren) rdata_q <= tcm[mem_addr];
    end

    // Reference model: CSR shadow, run window (m_t = cycle index inside the run), golden memory
    logic [31:0]   gold [0:(1<<WA)-1];
    logic [WA-1:0] m_sa = '0, m_sb = '0, m_sd = '0, m_pa = '0, m_pb = '0, m_pd = '0;
    logic [15:0]   m_len = '0;
    int            m_n = 0, m_t = 0;
    logic          m_busy = 1'b0, m_done = 1'b0;

    function automatic logic [WA-1:0] wadd(input logic [WA-1:0] b, input int i);
        return b + i[WA-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sa <= '0; m_sb <= '0; m_sd <= '0; m_len <= '0;
            m_pa <= '0; m_pb <= '0; m_pd <= '0;
            m_n <= 0; m_t <= 0; m_busy <= 1'b0; m_done <= 1'b0;
        end else if (m_busy) begin
            m_t <= m_t + 1;
            if (m_t == 3*m_n - 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (dmem_req && dmem_cmd == SCR1_MEM_CMD_WR && dmem_addr[31:5] == BASE[31:5]) begin
            case (dmem_addr[4:2])
                3'd0: m_sa  <= dmem_wdata[WA+1:2];
                3'd1: m_sb  <= dmem_wdata[WA+1:2];
                3'd2: m_sd  <= dmem_wdata[WA+1:2];
                3'd3: m_len <= dmem_wdata[15:0];
                3'd4: if (dmem_wdata[0]) begin
                    if (m_len == 16'd0) m_done <= 1'b1;
                    else begin
                        m_busy <= 1'b1; m_t <= 0; m_n <= int'(m_len);
                        m_pa <= m_sa; m_pb <= m_sb; m_pd <= m_sd; m_done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (poke_en) gold[poke_addr] <= poke_data;
        if (m_busy && (m_t % 3 == 2))
            gold[wadd(m_pd, m_t/3)] <= gold[wadd(m_pa, m_t/3)] + gold[wadd(m_pb, m_t/3)];
    end

    int            en_cycles = 0;
    logic [WA-1:0] ren_log [$];
    logic [3:0]    last_be = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic          e_ren, e_wen;
        logic [WA-1:0] e_addr;
        logic [31:0]   e_wdata;
        int            i, ph;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0;
        if (m_busy) begin
            i  = m_t / 3;
            ph = m_t % 3;
            e_ren = (ph != 2);
            e_wen = (ph == 2);
            e_addr = (ph == 0) ? wadd(m_pa, i) : (ph == 1) ? wadd(m_pb, i) : wadd(m_pd, i);
            if (ph == 2) e_wdata = gold[wadd(m_pa, i)] + gold[wadd(m_pb, i)];
        end
        chk("cyc_enable", enable, m_busy);
        chk("cyc_busy", acc_busy, m_busy);
        chk("cyc_ren", mem_ren, e_ren);
        chk("cyc_wen", mem_wen, e_wen);
        chk("cyc_be", mem_be, e_wen ? 4'hF : 4'h0);
        chk("cyc_addr", mem_addr, e_addr);
        chk("cyc_wdata", mem_wdata, e_wdata);
        chk("cyc_done", acc_done, m_done);
        if (enable === 1'b1) en_cycles++;
        if (mem_ren === 1'b1) ren_log.push_back(mem_addr);
        if (mem_wen === 1'b1) last_be = mem_be;
    endtask

    task automatic poke(input logic [WA-1:0] a, input logic [31:0] d);
        @(negedge clk); #2;
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk); #2;
        poke_en = 1'b0;
    endtask

    task automatic csr_wr(input logic [2:0] off, input logic [31:0] d);
        @(negedge clk); #2;
        dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_WR;
        dmem_addr = BASE | {27'd0, off, 2'b00}; dmem_wdata = d;
        @(negedge clk); #2;
        dmem_req = 1'b0; dmem_cmd = SCR1_MEM_CMD_RD;
    endtask

    task automatic setup(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d, input logic [31:0] n);
        csr_wr(3'd0, a);
        csr_wr(3'd1, b);
        csr_wr(3'd2, d);
        csr_wr(3'd3, n);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!(acc_done === 1'b1 && enable === 1'b0) && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 200) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int en0, rl0;
        #3 rst_n = 1'b0;
        #20;
        chk("rst_enable", enable, 0);
        chk("rst_done", acc_done, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_wdata", mem_wdata, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Zero length: done one cycle after CTRL, enable never rises
        csr_wr(3'd3, 32'd0);
        chk("zero_done_before", acc_done, 0);
        en0 = en_cycles;
        csr_wr(3'd4, 32'd1);
        chk("zero_done_after", acc_done, 1);
        repeat (3) @(negedge clk);
        #1 chk("zero_enable_cycles", en_cycles - en0, 0);

        // Basic add
        for (int i = 0; i < 4; i++) begin
            poke(WA'(14'h40 + i), 32'(i + 1));
            poke(WA'(14'h80 + i), 32'(10 * (i + 1)));
        end
        setup(32'h100, 32'h200, 32'h300, 32'd4);
        en0 = en_cycles;
        csr_wr(3'd4, 32'd1);
        wait_done("basic");
        chk("basic_c0", tcm[14'hC0], 32'd11);
        chk("basic_c1", tcm[14'hC1], 32'd22);
        chk("basic_c2", tcm[14'hC2], 32'd33);
        chk("basic_c3", tcm[14'hC3], 32'd44);
        chk("basic_enable_cycles", en_cycles - en0, 12);

        // Overflow
        poke(14'h10, 32'hFFFF_FFFF);
        poke(14'h20, 32'h0000_0002);
        setup(32'h40, 32'h80, 32'hC0, 32'd1);
        csr_wr(3'd4, 32'd1);
        wait_done("ovf");
        chk("ovf_result", tcm[14'h30], 32'h0000_0001);
        chk("ovf_be", last_be, 4'hF);

        // Pointer wrap
        poke(14'h3FFF, 32'd5);
        poke(14'h0000, 32'd7);
        poke(14'h0100, 32'd100);
        poke(14'h0101, 32'd200);
        setup(32'hFFFC, 32'h400, 32'h500, 32'd2);
        rl0 = ren_log.size();
        csr_wr(3'd4, 32'd1);
        wait_done("wrap");
        chk("wrap_second_a_addr", ren_log[rl0 + 2], 0);
        chk("wrap_c0", tcm[14'h140], 32'd105);
        chk("wrap_c1", tcm[14'h141], 32'd207);

        // Busy protection
        for (int i = 0; i < 3; i++) begin
            poke(WA'(14'h180 + i), 32'(i + 1));
            poke(WA'(14'h190 + i), 32'(10 * (i + 1)));
        end
        poke(14'h1A3, 32'hAAAA_5555);
        setup(32'h600, 32'h640, 32'h680, 32'd3);
        en0 = en_cycles;
        csr_wr(3'd4, 32'd1);
        csr_wr(3'd3, 32'd8);
        csr_wr(3'd4, 32'd1);
        wait_done("busy");
        chk("busy_enable_cycles", en_cycles - en0, 9);
        chk("busy_c2", tcm[14'h1A2], 32'd33);
        chk("busy_c3_untouched", tcm[14'h1A3], 32'hAAAA_5555);
        en0 = en_cycles;
        csr_wr(3'd4, 32'd1);
        wait_done("busy_rerun");
        chk("busy_len_readback", en_cycles - en0, 9);

        // Reset during RD_B of element 2
        for (int i = 0; i < 4; i++) begin
            poke(WA'(14'h200 + i), 32'(i + 1));
            poke(WA'(14'h210 + i), 32'(i + 5));
            poke(WA'(14'h220 + i), 32'hDEAD_BEEF);
        end
        setup(32'h800, 32'h840, 32'h880, 32'd4);
        rl0 = ren_log.size();
        csr_wr(3'd4, 32'd1);
        begin
            int k = 0;
            while (ren_log.size() - rl0 < 4 && k < 20) begin
                @(negedge clk); #1;
                k++;
            end
            if (k >= 20) chk("rst_mid_timeout", 32'd1, 32'd0);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_enable", enable, 0);
        chk("rst_mid_wen", mem_wen, 0);
        chk("rst_mid_done", acc_done, 0);
        chk("rst_mid_c0", tcm[14'h220], 32'd6);
        chk("rst_mid_c1", tcm[14'h221], 32'hDEAD_BEEF);
        chk("rst_mid_c3", tcm[14'h223], 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("rst_mid_c2", tcm[14'h222], 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_scr1_tcm_vadd_acc
